// File: rtl/rob_pkg.sv
// rob_pkg
//   Shared definitions for the reorder buffer: datapath widths, the
//   instruction type codes issued by the decoder, the per-entry payload
//   record and a small helper classifying control-flow instructions.
//   No ports (package).
package rob_pkg;

   localparam int XLEN       = 32;
   localparam int REG_W      = 5;
   localparam int TYPE_W     = 3;
   localparam int ROB_IDW    = 4;
   localparam int ROB_NUM_WB = 2;
   localparam int DEPTH      = 1 << ROB_IDW;

   typedef enum logic [TYPE_W-1:0] {
      ROB_ALU    = 3'd0,
      ROB_LOAD   = 3'd1,
      ROB_STORE  = 3'd2,
      ROB_BRANCH = 3'd3,
      ROB_JALR   = 3'd4
   } rob_type_e;

   // pred_pc keeps the decoder's guess; value/next_pc are overwritten by writeback.
   typedef struct packed {
      rob_type_e             rtype;
      logic [REG_W-1:0]      rd;
      logic [XLEN-1:0]       value;
      logic [XLEN-1:0]       pred_pc;
      logic [XLEN-1:0]       next_pc;
   } rob_entry_t;

   // Instructions whose actual next-PC is checked against the prediction.
   function automatic logic is_ctrl(input rob_type_e t);
      return (t == ROB_BRANCH) || (t == ROB_JALR);
   endfunction

endpackage

// File: rtl/rob_multi_wb_chk.sv
// rob_multi_wb_chk
//   Simulation checker for the reorder buffer writeback bus: flags two
//   channels writing the same ROB id in one enabled cycle.
//   Ports:
//     clk_in     in  1           system clock
//     rst_in     in  1           synchronous active-high reset
//     rdy_in     in  1           global enable
//     wb_valid   in  NUM_WB      writeback strobes
//     wb_rob_id  in  NUM_WB*IDW  writeback ids, channel 0 in the LSBs
module rob_multi_wb_chk
   import rob_pkg::*;
#(
   parameter int IDW    = ROB_IDW,
   parameter int NUM_WB = ROB_NUM_WB
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic [NUM_WB-1:0]     wb_valid,
   input  logic [NUM_WB*IDW-1:0] wb_rob_id
);

   logic dup_s;

   // Any pair of active channels carrying the same id.
   always_comb begin
      dup_s = 1'b0;
      for (int i = 0; i < NUM_WB; i++) begin
         for (int j = i + 1; j < NUM_WB; j++) begin
            dup_s = dup_s | (wb_valid[i] & wb_valid[j] &
                             (wb_rob_id[i*IDW +: IDW] == wb_rob_id[j*IDW +: IDW]));
         end
      end
   end

   // Duplicate ids are resolved by priority in the design but indicate an upstream bug.
   always_ff @(posedge clk_in) begin
      if (!rst_in && rdy_in) begin
         assert (!dup_s) else $error("rob_multi_wb: duplicate writeback id in one cycle");
      end
   end

endmodule

// File: rtl/rob_query_port.sv
// rob_query_port
//   One operand-status lookup. Reports the stored ready/value of the
//   queried entry, overridden by any same-cycle writeback to that id
//   (highest channel index wins).
//   Ports:
//     query_id     in   IDW         ROB id being looked up
//     entry_ready  in   1           stored ready bit of that entry
//     entry_value  in   XLEN        stored value of that entry
//     wb_valid     in   NUM_WB      qualified writeback strobes
//     wb_rob_id    in   NUM_WB*IDW  writeback ids, channel 0 in the LSBs
//     wb_value     in   NUM_WB*XLEN writeback results
//     ready        out  1           operand available
//     value        out  XLEN        operand value
module rob_query_port
   import rob_pkg::*;
#(
   parameter int IDW    = ROB_IDW,
   parameter int NUM_WB = ROB_NUM_WB
) (
   input  logic [IDW-1:0]         query_id,
   input  logic                   entry_ready,
   input  logic [XLEN-1:0]        entry_value,
   input  logic [NUM_WB-1:0]      wb_valid,
   input  logic [NUM_WB*IDW-1:0]  wb_rob_id,
   input  logic [NUM_WB*XLEN-1:0] wb_value,
   output logic                   ready,
   output logic [XLEN-1:0]        value
);

   logic hit_s;

   // Bypass: later channels overwrite earlier ones, so the highest index wins.
   always_comb begin
      ready = entry_ready;
      value = entry_value;
      hit_s = 1'b0;
      for (int ch = 0; ch < NUM_WB; ch++) begin
         hit_s = wb_valid[ch] && (wb_rob_id[ch*IDW +: IDW] == query_id);
         ready = ready | hit_s;
         value = hit_s ? wb_value[ch*XLEN +: XLEN] : value;
      end
   end

endmodule

// File: rtl/rob_multi_wb.sv
// rob_multi_wb
//   Reorder buffer with in-order issue/commit and NUM_WB writeback
//   channels. Retires at most one instruction per cycle: register-file
//   writes pulse the cycle after retirement, stores retire through a
//   req/ack handshake with the LSB, and a control op whose actual
//   next-PC differs from its prediction flushes the whole buffer.
//   Ports:
//     clk_in, rst_in, rdy_in            clock, sync active-high reset, global enable
//     _clear/_br_rob/_rob_new_pc        flush pulse and PC redirect
//     _rob_ready.._rob_value_ready      decoder issue interface
//     _rob_full/_rob_tail_id            allocation status
//     _get_register_status_N/_register_ready_N/_register_value_N  operand queries
//     _wb_valid/_wb_rob_id/_wb_value/_wb_next_pc  writeback channels (ch0 in LSBs)
//     _rf_commit_*                      register-file commit
//     _st_commit_req/_rob_id/_ack       store commit handshake
module rob_multi_wb
   import rob_pkg::*;
#(
   parameter int IDW    = $clog2(DEPTH),
   parameter int NUM_WB = ROB_NUM_WB
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   rdy_in,
   output logic                   _clear,
   output logic                   _br_rob,
   output logic [XLEN-1:0]        _rob_new_pc,
   input  logic                   _rob_ready,
   input  logic [TYPE_W-1:0]      _rob_type,
   input  logic [XLEN-1:0]        _rob_inst_addr,
   input  logic [REG_W-1:0]       _rob_rd,
   input  logic [XLEN-1:0]        _rob_value,
   input  logic                   _rob_value_ready,
   output logic                   _rob_full,
   output logic [IDW-1:0]         _rob_tail_id,
   input  logic [IDW-1:0]         _get_register_status_1,
   output logic                   _register_ready_1,
   output logic [XLEN-1:0]        _register_value_1,
   input  logic [IDW-1:0]         _get_register_status_2,
   output logic                   _register_ready_2,
   output logic [XLEN-1:0]        _register_value_2,
   input  logic [NUM_WB-1:0]      _wb_valid,
   input  logic [NUM_WB*IDW-1:0]  _wb_rob_id,
   input  logic [NUM_WB*XLEN-1:0] _wb_value,
   input  logic [NUM_WB*XLEN-1:0] _wb_next_pc,
   output logic                   _rf_commit_ready,
   output logic [IDW-1:0]         _rf_commit_rob_id,
   output logic [REG_W-1:0]       _rf_commit_register_id,
   output logic [XLEN-1:0]        _rf_commit_value,
   output logic                   _st_commit_req,
   output logic [IDW-1:0]         _st_commit_rob_id,
   input  logic                   _st_commit_ack
);

   localparam int             ROB_DEPTH  = 1 << IDW;
   localparam logic [IDW:0]   FULL_COUNT = (IDW+1)'(ROB_DEPTH);

   rob_entry_t              ent_r [ROB_DEPTH];
   logic [ROB_DEPTH-1:0]    busy_r;
   logic [ROB_DEPTH-1:0]    ready_r;
   logic [IDW-1:0]          head_r;
   logic [IDW-1:0]          tail_r;
   logic [IDW:0]            count_r;

   logic                    clear_r;
   logic                    br_rob_r;
   logic [XLEN-1:0]         new_pc_r;
   logic                    rf_ready_r;
   logic [IDW-1:0]          rf_id_r;
   logic [REG_W-1:0]        rf_rd_r;
   logic [XLEN-1:0]         rf_value_r;
   logic                    st_req_r;
   logic [IDW-1:0]          st_id_r;

   rob_entry_t              head_ent_s;
   logic                    head_ready_s;
   logic                    head_is_store_s;
   logic                    mispredict_s;
   logic                    retire_s;
   logic                    flush_s;
   logic                    issue_s;
   logic [NUM_WB-1:0]       wb_en_s;

   // The instruction PC is carried for debug visibility only; commit needs just next-PC data.
   logic                    unused_inst_addr_s;
   assign unused_inst_addr_s = ^_rob_inst_addr;

   assign _rob_full    = (count_r == FULL_COUNT);
   assign _rob_tail_id = tail_r;
   assign wb_en_s      = _wb_valid & {NUM_WB{rdy_in & ~rst_in}};

   // Head inspection and per-cycle issue / retire / flush decisions.
   always_comb begin
      head_ent_s      = ent_r[head_r];
      head_ready_s    = busy_r[head_r] & ready_r[head_r];
      head_is_store_s = (head_ent_s.rtype == ROB_STORE);
      mispredict_s    = is_ctrl(head_ent_s.rtype) && (head_ent_s.next_pc != head_ent_s.pred_pc);
      if (head_is_store_s) begin
         // A store retires only once the LSB acknowledges the registered request.
         retire_s = rdy_in & head_ready_s & st_req_r & _st_commit_ack;
      end else begin
         retire_s = rdy_in & head_ready_s;
      end
      flush_s = retire_s & mispredict_s;
      issue_s = rdy_in & _rob_ready & ~_rob_full & ~_clear;
   end

   // Buffer state: writeback, allocation, retirement and flush.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
         busy_r  <= '0;
         ready_r <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) begin
            ent_r[i] <= '0;
         end
      end else if (rdy_in) begin
         if (flush_s) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            busy_r  <= '0;
            ready_r <= '0;
         end else begin
            // Writes to entries that are not allocated are stale and ignored.
            for (int ch = 0; ch < NUM_WB; ch++) begin
               if (wb_en_s[ch] && busy_r[_wb_rob_id[ch*IDW +: IDW]]) begin
                  ready_r[_wb_rob_id[ch*IDW +: IDW]]       <= 1'b1;
                  ent_r[_wb_rob_id[ch*IDW +: IDW]].value   <= _wb_value[ch*XLEN +: XLEN];
                  ent_r[_wb_rob_id[ch*IDW +: IDW]].next_pc <= _wb_next_pc[ch*XLEN +: XLEN];
               end
            end
            if (issue_s) begin
               // next_pc starts equal to the prediction so an op without writeback never mispredicts.
               ent_r[tail_r] <= '{rtype:   rob_type_e'(_rob_type),
                                  rd:      _rob_rd,
                                  value:   _rob_value,
                                  pred_pc: _rob_value,
                                  next_pc: _rob_value};
               busy_r[tail_r]  <= 1'b1;
               ready_r[tail_r] <= _rob_value_ready;
               tail_r          <= tail_r + IDW'(1);
            end
            if (retire_s) begin
               busy_r[head_r]  <= 1'b0;
               ready_r[head_r] <= 1'b0;
               head_r          <= head_r + IDW'(1);
            end
            case ({issue_s, retire_s})
               2'b10:   count_r <= count_r + (IDW+1)'(1);
               2'b01:   count_r <= count_r - (IDW+1)'(1);
               default: count_r <= count_r;
            endcase
         end
      end
   end

   // Registered commit, redirect and store-request outputs.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         clear_r    <= 1'b0;
         br_rob_r   <= 1'b0;
         new_pc_r   <= '0;
         rf_ready_r <= 1'b0;
         rf_id_r    <= '0;
         rf_rd_r    <= '0;
         rf_value_r <= '0;
         st_req_r   <= 1'b0;
         st_id_r    <= '0;
      end else if (!rdy_in) begin
         clear_r    <= 1'b0;
         br_rob_r   <= 1'b0;
         rf_ready_r <= 1'b0;
      end else begin
         clear_r    <= 1'b0;
         br_rob_r   <= 1'b0;
         rf_ready_r <= 1'b0;
         if (retire_s && !head_is_store_s) begin
            rf_ready_r <= (head_ent_s.rd != '0);
            rf_id_r    <= head_r;
            rf_rd_r    <= head_ent_s.rd;
            rf_value_r <= head_ent_s.value;
         end
         if (flush_s) begin
            clear_r  <= 1'b1;
            br_rob_r <= 1'b1;
            new_pc_r <= head_ent_s.next_pc;
         end
         // Request drops the cycle after the acknowledged store retires.
         st_req_r <= head_ready_s & head_is_store_s & ~retire_s;
         st_id_r  <= head_r;
      end
   end

   assign _clear                 = clear_r;
   assign _br_rob                = br_rob_r;
   assign _rob_new_pc            = new_pc_r;
   assign _rf_commit_ready       = rf_ready_r;
   assign _rf_commit_rob_id      = rf_id_r;
   assign _rf_commit_register_id = rf_rd_r;
   assign _rf_commit_value       = rf_value_r;
   assign _st_commit_req         = st_req_r;
   assign _st_commit_rob_id      = st_id_r;

   rob_query_port #(.IDW(IDW), .NUM_WB(NUM_WB)) u_query_1 (
      .query_id    (_get_register_status_1),
      .entry_ready (ready_r[_get_register_status_1]),
      .entry_value (ent_r[_get_register_status_1].value),
      .wb_valid    (wb_en_s),
      .wb_rob_id   (_wb_rob_id),
      .wb_value    (_wb_value),
      .ready       (_register_ready_1),
      .value       (_register_value_1)
   );

   rob_query_port #(.IDW(IDW), .NUM_WB(NUM_WB)) u_query_2 (
      .query_id    (_get_register_status_2),
      .entry_ready (ready_r[_get_register_status_2]),
      .entry_value (ent_r[_get_register_status_2].value),
      .wb_valid    (wb_en_s),
      .wb_rob_id   (_wb_rob_id),
      .wb_value    (_wb_value),
      .ready       (_register_ready_2),
      .value       (_register_value_2)
   );

   rob_multi_wb_chk #(.IDW(IDW), .NUM_WB(NUM_WB)) u_chk (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .rdy_in    (rdy_in),
      .wb_valid  (_wb_valid),
      .wb_rob_id (_wb_rob_id)
   );

endmodule
